mult_sequencer: RTL
===================

// Module: mult_sequencer
// PURPOSE
//  Control FSM + registers for a signed add-shift multiplier built around the shared adder.
//  Multiplies accumulator/multiplier pair by S: {X,A,B} <= B * S (two's complement), one bit per iteration.
//  Drives an external WIDTH+1-bit adder via operand ports and captures its sum; sits between switches/Run and hex displays.
// PARAMETERS
//  WIDTH  8  operand width of S, A and B; product is 2*WIDTH bits in {A,B}.
// PORTS
//  Clk           in   1        clock; all state updates on rising edge
//  Reset         in   1        asynchronous, active-high reset
//  Run           in   1        level; start multiply when high in IDLE
//  ClearA_LoadB  in   1        level; in IDLE: A<=0, X<=0, B<=S
//  S             in   WIDTH    multiplicand / load value
//  adder_a       out  WIDTH+1  adder operand a = {A[W-1],A}
//  adder_b       out  WIDTH+1  adder operand b = {S[W-1],S}, bitwise inverted when subtracting
//  adder_cin     out  1        1 when subtracting, else 0
//  adder_sum     in   WIDTH+1  a+b+cin from external adder, combinational, same cycle
//  Aval          out  WIDTH    accumulator register A (product high half)
//  Bval          out  WIDTH    multiplier register B (product low half)
//  X             out  1        sign-extension bit
//  busy          out  1        high in ADD/SHIFT states
//  done          out  1        high in DONE state
// BEHAVIOUR
//  Reset (any time, incl. mid-operation): A=0, B=0, X=0, count=0, state=IDLE, busy=0, done=0.
//  States: IDLE, ADD, SHIFT, DONE. count is $clog2(WIDTH)+1 bits.
//  IDLE: ClearA_LoadB=1 -> load (A=0,X=0,B=S), stay IDLE; takes priority over Run same cycle.
//    else Run=1 -> A<=0, X<=0, count<=0, go ADD. B retained.
//  ADD: if B[0]=1: {X,A} <= adder_sum; else A,X hold. Subtract (adder_cin=1, b inverted)
//    only when count==WIDTH-1; otherwise add. Always -> SHIFT.
//  SHIFT: {X,A,B} <= {X,X,A,B[W-1:1]} (arith right shift, X kept); count++.
//    count==WIDTH-1 before increment -> DONE, else -> ADD.
//  DONE: hold A,B,X; done=1. Run=0 -> IDLE. Run held high never restarts (one multiply per Run pulse).
//  Latency: Run sampled high in IDLE -> done=1 after exactly 2*WIDTH+1 edges (16 ADD/SHIFT + entry).
//  S must be stable during busy; S change mid-operation is used as-is (no latching).
//  ClearA_LoadB ignored while busy or in DONE.
//  adder_a/adder_b/adder_cin are driven in every state (combinational from A,S,count); only
//    captured in ADD with B[0]=1.
//  Aval/Bval/X outputs are register values, no extra latency.
// CONFIGURATION
//  MULT_SKIP_ADD_EN defined: in ADD-entry decision, if B[0]=0 the FSM goes SHIFT->SHIFT directly
//    (ADD state bypassed); latency = WIDTH + popcount(B_initial) + 1 edges. Results identical.
//  Undefined: fixed ADD/SHIFT alternation, latency 2*WIDTH+1 regardless of data.
// TESTING
//  Assert Reset mid-cycle (async, no edge) -> Aval=0, Bval=0, X=0, busy=0, done=0 immediately.
//  S=0x07, ClearA_LoadB pulse; S=0x3B, Run=1 -> after 17 edges done=1, Aval=0x01, Bval=0x9D, X=0.
//  B=0xF9 (-7), S=0x3B (59), Run -> Aval=0xFE, Bval=0x63, X=1 (-413); last-bit subtract exercised.
//  B=0x80, S=0x80, Run -> Aval=0x40, Bval=0x00, X=0 (+16384); min*min boundary.
//  Hold Run=1 after done -> values hold, no restart; Run 0->1 with B=0x9D,S=0x02 -> {A,B} = 0xFF3A (A cleared first).
//  Reset asserted at count=3 of a multiply -> IDLE, all zero; next load/Run 0x07*0x3B gives 0x019D.
//  With MULT_SKIP_ADD_EN: B=0x01, S=0x05 -> done after 10 edges, Aval=0x00, Bval=0x05.

Source files
------------

// File: rtl/mult_sequencer.sv
// Sequencer and A/B/X registers for a signed add-shift multiplier driving an external WIDTH+1-bit adder.
// Optional macro MULT_SKIP_ADD_EN: skip the ADD state whenever the current multiplier bit is zero.
module mult_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Run,
    input  logic               ClearA_LoadB,
    input  logic [WIDTH-1:0]   S,
    output logic [WIDTH:0]     adder_a,
    output logic [WIDTH:0]     adder_b,
    output logic               adder_cin,
    input  logic [WIDTH:0]     adder_sum,
    output logic [WIDTH-1:0]   Aval,
    output logic [WIDTH-1:0]   Bval,
    output logic               X,
    output logic               busy,
    output logic               done
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  A_q, A_d;
    logic [WIDTH-1:0]  B_q, B_d;
    logic              X_q, X_d;
    logic [CW-1:0]     count_q, count_d;
    logic              sub;
    logic [WIDTH:0]    s_ext;

    // State that handles the next multiplier bit; a zero bit needs no add when skipping is enabled.
    function automatic state_t bit_state(input logic b);
`ifdef MULT_SKIP_ADD_EN
        return b ? ADD : SHIFT;
`else
        return (b | ~b) ? ADD : ADD;
`endif
    endfunction

    // The sign bit of a two's complement multiplier has negative weight, so the last step subtracts.
    assign sub       = (count_q == LAST);
    assign s_ext     = {S[WIDTH-1], S};
    assign adder_a   = {A_q[WIDTH-1], A_q};
    assign adder_b   = sub ? ~s_ext : s_ext;
    assign adder_cin = sub;

    assign Aval = A_q;
    assign Bval = B_q;
    assign X    = X_q;
    assign busy = (state_q == ADD) || (state_q == SHIFT);
    assign done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        A_d     = A_q;
        B_d     = B_q;
        X_d     = X_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (ClearA_LoadB) begin
                    A_d = '0;
                    X_d = 1'b0;
                    B_d = S;
                end else if (Run) begin
                    A_d     = '0;
                    X_d     = 1'b0;
                    count_d = '0;
                    state_d = bit_state(B_q[0]);
                end
            end
            ADD: begin
                if (B_q[0]) begin
                    {X_d, A_d} = adder_sum;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                {X_d, A_d, B_d} = {X_q, X_q, A_q, B_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
                // B_q[1] is the bit that lands in B[0] on this shift.
                state_d = (count_q == LAST) ? DONE : bit_state(B_q[1]);
            end
            DONE: begin
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            A_q     <= '0;
            B_q     <= '0;
            X_q     <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            A_q     <= A_d;
            B_q     <= B_d;
            X_q     <= X_d;
            count_q <= count_d;
        end
    end
endmodule
